game_ctrl: RTL and testbench

Top-level game sequencer for the Tom & Jerry game. Takes the registered 2-bit game-over code from the collision/cheese checker and a start button, then steps through idle, countdown, play and end-of-round screens. It drives the soft reset and movement enable for the character and cheese logic, the state code and countdown digit for the display overlay, and saturating per-character win counters.

---
 rtl/game_ctrl.sv | 136 +++++++++++++
 tb/tb_game_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Round sequencer for the Tom & Jerry game: idle, countdown, play and end screens,
// with soft reset / movement enable for the playfield and saturating win counters.
module game_ctrl #(
    parameter int TICK_DIV        = 65_000_000,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int HOLD_TICKS      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic [1:0] gameover,
    output logic       game_rst,
    output logic       move_en,
    output logic [2:0] state,
    output logic [1:0] countdown,
    output logic [1:0] winner,
    output logic [3:0] tom_wins,
    output logic [3:0] jerry_wins
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [1:0]    CD_INIT   = 2'(COUNTDOWN_TICKS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_TOM_WIN   = 3'd3,
        S_JERRY_WIN = 3'd4
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [HW-1:0] r_hold;
    logic          r_btn_prev;
    logic          r_press;
    logic          r_game_rst;
    logic          r_move_en;
    logic [1:0]    r_countdown;
    logic [1:0]    r_winner;
    logic [3:0]    r_tom_wins;
    logic [3:0]    r_jerry_wins;
    logic          w_tick;

    assign w_tick = (r_presc == PRESC_MAX);

    // Every transition also zeroes the prescaler so each state starts a full tick period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_presc      <= '0;
            r_hold       <= '0;
            r_btn_prev   <= 1'b1;
            r_press      <= 1'b0;
            r_game_rst   <= 1'b1;
            r_move_en    <= 1'b0;
            r_countdown  <= 2'd0;
            r_winner     <= 2'b00;
            r_tom_wins   <= 4'd0;
            r_jerry_wins <= 4'd0;
        end else begin
            r_btn_prev <= start_btn;
            r_press    <= start_btn & ~r_btn_prev;
            r_presc    <= w_tick ? '0 : r_presc + PW'(1);
            case (r_state)
                S_IDLE: begin
                    if (r_press) begin
                        r_state     <= S_COUNTDOWN;
                        r_countdown <= CD_INIT;
                        r_presc     <= '0;
                    end
                end
                S_COUNTDOWN: begin
                    if (w_tick) begin
                        if (r_countdown == 2'd1) begin
                            r_state     <= S_PLAY;
                            r_countdown <= 2'd0;
                            r_game_rst  <= 1'b0;
                            r_move_en   <= 1'b1;
                            r_presc     <= '0;
                        end else begin
                            r_countdown <= r_countdown - 2'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // gameover 11 counts as a catch, so bit 1 alone decides Tom.
                    if (gameover[1]) begin
                        r_state   <= S_TOM_WIN;
                        r_winner  <= 2'b10;
                        r_move_en <= 1'b0;
                        r_hold    <= '0;
                        r_presc   <= '0;
                        if (r_tom_wins != 4'd15) r_tom_wins <= r_tom_wins + 4'd1;
                    end else if (gameover[0]) begin
                        r_state   <= S_JERRY_WIN;
                        r_winner  <= 2'b01;
                        r_move_en <= 1'b0;
                        r_hold    <= '0;
                        r_presc   <= '0;
                        if (r_jerry_wins != 4'd15) r_jerry_wins <= r_jerry_wins + 4'd1;
                    end
                end
                S_TOM_WIN, S_JERRY_WIN: begin
                    if (w_tick && (r_hold != HOLD_MAX)) r_hold <= r_hold + HW'(1);
                    if (r_press && (r_hold == HOLD_MAX)) begin
                        r_state     <= S_COUNTDOWN;
                        r_countdown <= CD_INIT;
                        r_game_rst  <= 1'b1;
                        r_move_en   <= 1'b0;
                        r_presc     <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_game_rst  <= 1'b1;
                    r_move_en   <= 1'b0;
                    r_countdown <= 2'd0;
                    r_presc     <= '0;
                end
            endcase
        end
    end

    assign state      = r_state;
    assign game_rst   = r_game_rst;
    assign move_en    = r_move_en;
    assign countdown  = r_countdown;
    assign winner     = r_winner;
    assign tom_wins   = r_tom_wins;
    assign jerry_wins = r_jerry_wins;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl with a fast tick (TICK_DIV=4); round results are queued when
// gameover is driven and compared when the DUT leaves PLAY.
module tb_game_ctrl;

  localparam int TICK_DIV        = 4;
  localparam int COUNTDOWN_TICKS = 3;
  localparam int HOLD_TICKS      = 2;

  logic       clk;
  logic       rst;
  logic       start_btn;
  logic [1:0] gameover;
  logic       game_rst;
  logic       move_en;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [1:0] winner;
  logic [3:0] tom_wins;
  logic [3:0] jerry_wins;

  int checks;
  int failures;
  logic [3:0] m_tom;
  logic [3:0] m_jerry;
  logic [12:0] exp_q[$];

  game_ctrl #(
    .TICK_DIV(TICK_DIV),
    .COUNTDOWN_TICKS(COUNTDOWN_TICKS),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_btn(start_btn),
    .gameover(gameover),
    .game_rst(game_rst),
    .move_en(move_en),
    .state(state),
    .countdown(countdown),
    .winner(winner),
    .tom_wins(tom_wins),
    .jerry_wins(jerry_wins)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = (state == s);
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (state == s);
    end
  endtask

  task automatic restart_round(output bit ok);
    repeat (HOLD_TICKS * TICK_DIV) step();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    wait_state(3'd2, 40, ok);
  endtask

  task automatic end_round(input logic [1:0] go, input string name);
    logic [12:0] exp_v;
    logic [12:0] got_v;
    if (go[1]) begin
      if (m_tom != 4'd15) m_tom = m_tom + 4'd1;
      exp_q.push_back({3'd3, 2'b10, m_tom, m_jerry});
    end else begin
      if (m_jerry != 4'd15) m_jerry = m_jerry + 4'd1;
      exp_q.push_back({3'd4, 2'b01, m_tom, m_jerry});
    end
    gameover = go;
    step();
    gameover = 2'b00;
    exp_v = exp_q.pop_front();
    got_v = {state, winner, tom_wins, jerry_wins};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s state/winner/tom/jerry got=%h exp=%h", name, got_v, exp_v);
    end
  endtask

  // scenario tasks
  task automatic test_reset();
    rst = 1'b1;
    start_btn = 1'b0;
    gameover = 2'b00;
    repeat (3) step();
    rst = 1'b0;
    repeat (50) step();
    checks++;
    if ({state, game_rst, move_en, countdown, winner, tom_wins, jerry_wins} !==
        {3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL reset_idle got st=%0d grst=%b men=%b cd=%0d win=%b tom=%0d jer=%0d exp st=0 grst=1 men=0 rest 0",
               state, game_rst, move_en, countdown, winner, tom_wins, jerry_wins);
    end
  endtask

  task automatic test_countdown();
    rst = 1'b1;
    start_btn = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL held_btn_idle state got=%0d exp=0", state);
    end
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL press_latency state got=%0d exp=0", state);
    end
    step();
    checks++;
    if (state !== 3'd1 || countdown !== 2'd3) begin
      failures++;
      $display("FAIL countdown_entry got st=%0d cd=%0d exp st=1 cd=3", state, countdown);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      start_btn = 1'b0;
      checks++;
      if (k < 12) begin
        if (state !== 3'd1 || countdown !== 2'(3 - k / 4)) begin
          failures++;
          $display("FAIL countdown_cyc%0d got st=%0d cd=%0d exp st=1 cd=%0d", k, state, countdown, 3 - k / 4);
        end
      end else begin
        if (state !== 3'd2 || move_en !== 1'b1 || game_rst !== 1'b0 || countdown !== 2'd0) begin
          failures++;
          $display("FAIL play_entry got st=%0d men=%b grst=%b cd=%0d exp st=2 men=1 grst=0 cd=0",
                   state, move_en, game_rst, countdown);
        end
      end
    end
  endtask

  task automatic test_tom_win();
    bit ok;
    end_round(2'b10, "tom_win");
    checks++;
    if (move_en !== 1'b0 || game_rst !== 1'b0) begin
      failures++;
      $display("FAIL tom_win_freeze got men=%b grst=%b exp men=0 grst=0", move_en, game_rst);
    end
    repeat (2) step();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL early_press state got=%0d exp=3", state);
    end
    repeat (4) step();
    checks++;
    if (state !== 3'd3) begin
      failures++;
      $display("FAIL no_queued_press state got=%0d exp=3", state);
    end
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    checks++;
    if (state !== 3'd1 || countdown !== 2'd3 || game_rst !== 1'b1) begin
      failures++;
      $display("FAIL restart got st=%0d cd=%0d grst=%b exp st=1 cd=3 grst=1", state, countdown, game_rst);
    end
    wait_state(3'd2, 20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL restart_play timeout state got=%0d exp=2", state);
    end
  endtask

  task automatic test_press_and_gameover();
    bit ok;
    start_btn = 1'b1;
    step();
    end_round(2'b11, "gameover11_with_press");
    start_btn = 1'b0;
    restart_round(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL jerry_round_start timeout state got=%0d exp=2", state);
    end
    end_round(2'b01, "jerry_win");
  endtask

  task automatic test_saturation();
    bit ok;
    for (int r = 0; r < 16; r++) begin
      restart_round(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL sat_round%0d start timeout state got=%0d exp=2", r, state);
      end
      end_round(2'b10, "tom_saturate");
    end
    checks++;
    if (tom_wins !== 4'd15) begin
      failures++;
      $display("FAIL tom_sat_value got=%0d exp=15", tom_wins);
    end
  endtask

  task automatic test_gameover_ignored();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    repeat (HOLD_TICKS * TICK_DIV + 2) begin
      if (state == 3'd3) begin
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
      end
      step();
    end
    gameover = 2'b10;
    repeat (5) step();
    checks++;
    if (state !== 3'd1 || tom_wins !== m_tom) begin
      failures++;
      $display("FAIL gameover_in_countdown got st=%0d tom=%0d exp st=1 tom=%0d", state, tom_wins, m_tom);
    end
    gameover = 2'b00;
  endtask

  task automatic test_async_reset();
    bit ok;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_tom = 4'd0;
    m_jerry = 4'd0;
    checks++;
    if ({state, game_rst, move_en, countdown, winner, tom_wins, jerry_wins} !==
        {3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL async_rst_countdown got st=%0d grst=%b men=%b cd=%0d win=%b tom=%0d jer=%0d exp reset values",
               state, game_rst, move_en, countdown, winner, tom_wins, jerry_wins);
    end
    #1;
    rst = 1'b0;
    gameover = 2'b10;
    repeat (3) step();
    checks++;
    if (state !== 3'd0 || tom_wins !== 4'd0) begin
      failures++;
      $display("FAIL gameover_in_idle got st=%0d tom=%0d exp st=0 tom=0", state, tom_wins);
    end
    gameover = 2'b00;
    restart_round(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL post_reset_round timeout state got=%0d exp=2", state);
    end
    end_round(2'b10, "post_reset_tom_win");
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({state, game_rst, move_en, countdown, winner, tom_wins, jerry_wins} !==
        {3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 4'd0}) begin
      failures++;
      $display("FAIL async_rst_tomwin got st=%0d grst=%b men=%b cd=%0d win=%b tom=%0d jer=%0d exp reset values",
               state, game_rst, move_en, countdown, winner, tom_wins, jerry_wins);
    end
    #1;
    rst = 1'b0;
    step();
  endtask

  // main sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    m_tom = 4'd0;
    m_jerry = 4'd0;
    rst = 1'b1;
    start_btn = 1'b0;
    gameover = 2'b00;
    test_reset();
    test_countdown();
    test_tom_win();
    test_press_and_gameover();
    test_saturation();
    test_gameover_ignored();
    repeat (2) step();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d entries exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
